jpeg_quant: RTL and testbench
=============================

# jpeg_quant

Quantizer stage of the JPEG accelerator, directly downstream of the 8x8 transpose buffer. It accepts one 8-element column of 12-bit signed DCT coefficients per valid cycle and multiplies each element by a programmable 16-bit reciprocal of its quantization step. It rounds the products and emits one quantized 12-bit column two cycles later, tracking column position within the 8x8 block. The reciprocal table is written by the CPU-side control logic.

## Interface
- COLS, 8: columns per block; also vector width.
- CW, 12: coefficient width, signed, for both input and output.
- RW, 16: reciprocal width, unsigned, Q16 fraction.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_vld  in  1  data_in holds a valid column this cycle.
- data_in  in  [7:0][11:0]  column vector; element r is block row r.
- qt_we  in  1  table write strobe.
- qt_addr  in  6  table index = row*8 + col (row-major).
- qt_data  in  16  reciprocal, round(65536/Q) saturated to 16'hFFFF.
- out_vld  out  1  data_out valid.
- data_out  out  [7:0][11:0]  quantized column.
- out_col  out  3  column index of data_out within the block.
- blk_done  out  1  high with out_vld on column 7.

## Operation
- Column counter `col`, 3 bits, reset 0. It increments on each in_vld and wraps 7->0. There is no other way to advance it.
- Lane r, for r in 0..7, computes p = data_in[r] * $signed({1'b0, tbl[r*8+col]}) as a 29-bit signed value.
- Rounding is half away from zero:
  - q = (p + 32768) >>> 16 when p >= 0.
  - q = (p + 32767) >>> 16 when p < 0.
- Overflow cannot occur: |data_in| <= 2048 and reciprocal < 2^16 give |q| <= 2048. q is truncated to 12 bits with no saturation logic.
- Table:
  - 64 x 16 register file with 8 combinational read ports indexed by the current col.
  - Reset value of every entry is 16'hFFFF. This is identity: q == data_in for all 12-bit inputs.
- Write vs read in the same cycle: the read uses the old value. The write is visible from the next cycle.
- Writes may occur at any time, including mid-block. The bench and firmware only rewrite between blocks.
- No backpressure. The consumer must accept out_vld every cycle it is asserted. in_vld may be asserted back-to-back indefinitely.
- in_vld gaps of any length are allowed. The pipeline holds no state beyond its valid bits, and col is kept across gaps.

## Timing
- Pipeline has 2 stages, so latency is 2 cycles from the in_vld edge to the out_vld edge.
- S1 registers: products p[7:0], valid v1, column c1, flag last1 (col==7).
- S2 registers: rounded q[7:0], out_vld, out_col, blk_done.
- Throughput is 1 column per cycle, so one block is 8 accepted columns.
- Reset values: out_vld=0, blk_done=0, out_col=0, data_out=0, col=0, v1=0, all table entries 16'hFFFF.
- Reset asserted mid-block: pipeline contents are discarded immediately (asynchronous) and the table returns to identity. The next in_vld after release is column 0.
- blk_done is a single-cycle pulse, coincident with out_vld, when out_col==7.

## Structure
- Shared package `jpeg_pkg` holds:
  - coef_t (logic signed [11:0]) and recip_t (logic [15:0]).
  - Constants BLK_DIM=8 and QT_ENTRIES=64.
  - Constant QT_RESET=16'hFFFF.
- Sub-module `jpeg_quant_lane` contains one multiply, the S1 register, the rounding logic and the S2 register. It is instantiated 8 times.
- The parent holds the table, col counter, valid/column/done pipeline and write port.
- The lane has no knowledge of the table.

## Test plan
- Reset, identity table: 8 columns with every element = 100, then -2048, then 2047. Required: out identical to input 2 cycles later; out_col 0..7; blk_done on the 8th output only.
- Write tbl[0]=4096 (Q=16), then drive column 0 with row0 values 7, 8, -8, -7. Required: row0 out 0, 1, -1, 0 (half away from zero); rows 1-7 unchanged.
- Back-to-back stream of 16 columns with 3 idle cycles inserted after column 5. Required: col continues 6,7 after the gap; two blk_done pulses; no dropped or duplicated outputs.
- qt_we to tbl[r*8+col] in the same cycle as the in_vld that reads it. Required: old value used; new value applies from the next cycle. Next block, same column, uses the new value.
- Assert rst after column 3 while v1=1. Required: out_vld=0 immediately and the in-flight result is never emitted. The table reads 16'hFFFF and the next input is out_col 0.
- Random table with Q in 1..255 and random inputs over 100 blocks, checked against a reference model of the formula above. Required: zero mismatches.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG quantizer stage.
package jpeg_pkg;
  typedef logic signed [11:0] coef_t;
  typedef logic [15:0]        recip_t;

  localparam int     BLK_DIM    = 8;
  localparam int     QT_ENTRIES = 64;
  localparam int     CW         = 12;
  localparam int     RW         = 16;
  localparam recip_t QT_RESET   = 16'hFFFF;
endpackage

// File: rtl/jpeg_quant_lane.sv
// One quantizer lane: multiply by a Q16 reciprocal, register, round half away
// from zero, register.
module jpeg_quant_lane
  import jpeg_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ld1_i,
  input  logic   ld2_i,
  input  coef_t  coef_i,
  input  recip_t recip_i,
  output coef_t  q_o
);

  logic signed [16:0] recip_s;
  logic signed [28:0] p_d;
  logic signed [28:0] p_q;
  logic signed [28:0] sum;
  coef_t              q_d;
  coef_t              q_q;
  logic               lane_unused;

  assign recip_s = $signed({1'b0, recip_i});
  assign p_d     = 29'(coef_i) * 29'(recip_s);

  // Negative products add one less so ties round away from zero after the
  // flooring arithmetic shift; bits [27:16] are that shifted value truncated.
  assign sum         = p_q + (p_q[28] ? 29'sd32767 : 29'sd32768);
  assign q_d         = sum[27:16];
  assign lane_unused = ^{sum[28], sum[15:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q <= '0;
      q_q <= '0;
    end else begin
      if (ld1_i) p_q <= p_d;
      if (ld2_i) q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/jpeg_quant.sv
// JPEG quantizer: reciprocal table, column counter and 8 two-stage lanes.
module jpeg_quant
  import jpeg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [7:0][11:0] data_in,
  input  logic             qt_we,
  input  logic [5:0]       qt_addr,
  input  logic [15:0]      qt_data,
  output logic             out_vld,
  output logic [7:0][11:0] data_out,
  output logic [2:0]       out_col,
  output logic             blk_done
);

  // Valid-only streaming: in_vld high means data_in is consumed that edge;
  // out_vld high means data_out/out_col/blk_done must be taken that cycle.
  recip_t     tbl_q [QT_ENTRIES];
  logic [2:0] col_q;
  logic [2:0] col_d;
  logic       v1_q;
  logic [2:0] c1_q;
  logic       last1_q;
  logic       out_vld_q;
  logic [2:0] out_col_q;
  logic       blk_done_q;
  coef_t      lane_q [BLK_DIM];

  // Reads see the pre-write contents; a write lands at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QT_ENTRIES; i++) tbl_q[i] <= QT_RESET;
    end else if (qt_we) begin
      tbl_q[qt_addr] <= qt_data;
    end
  end

  assign col_d = in_vld ? col_q + 3'd1 : col_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      v1_q       <= 1'b0;
      c1_q       <= '0;
      last1_q    <= 1'b0;
      out_vld_q  <= 1'b0;
      out_col_q  <= '0;
      blk_done_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      v1_q       <= in_vld;
      out_vld_q  <= v1_q;
      blk_done_q <= v1_q & last1_q;
      if (in_vld) begin
        c1_q    <= col_q;
        last1_q <= (col_q == 3'd7);
      end
      if (v1_q) out_col_q <= c1_q;
    end
  end

  for (genvar r = 0; r < BLK_DIM; r++) begin : g_lane
    localparam logic [2:0] ROW = 3'(r);

    jpeg_quant_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .ld1_i   (in_vld),
      .ld2_i   (v1_q),
      .coef_i  (coef_t'(data_in[r])),
      .recip_i (tbl_q[{ROW, col_q}]),
      .q_o     (lane_q[r])
    );

    assign data_out[r] = lane_q[r];
  end

  assign out_vld  = out_vld_q;
  assign out_col  = out_col_q;
  assign blk_done = blk_done_q;

endmodule

// File: tb/tb_jpeg_quant.sv
// Scoreboard bench for jpeg_quant: stimulus pushes expected columns, a monitor
// pops and compares whenever out_vld is seen.
module tb_jpeg_quant;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld;
  logic [7:0][11:0] data_in;
  logic             qt_we;
  logic [5:0]       qt_addr;
  logic [15:0]      qt_data;
  logic             out_vld;
  logic [7:0][11:0] data_out;
  logic [2:0]       out_col;
  logic             blk_done;

  jpeg_quant dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .data_in  (data_in),
    .qt_we    (qt_we),
    .qt_addr  (qt_addr),
    .qt_data  (qt_data),
    .out_vld  (out_vld),
    .data_out (data_out),
    .out_col  (out_col),
    .blk_done (blk_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [99:0] exp_q[$];      // {done, col, data}
  logic [15:0] tb_tbl [64];
  logic [2:0]  tb_col;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [11:0] ref_q(input logic [11:0] x, input logic [15:0] rcp);
    longint p;
    longint q;
    p = longint'($signed(x)) * longint'(rcp);
    if (p >= 0) q = (p + 32768) >>> 16;
    else        q = (p + 32767) >>> 16;
    return q[11:0];
  endfunction

  function automatic logic [95:0] splat(input logic [11:0] v);
    return {8{v}};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic vld, input logic [7:0][11:0] d, input logic [7:0][11:0] e,
                       input logic we, input logic [5:0] a, input logic [15:0] w);
    @(posedge clk);
    #1;
    in_vld  = vld;
    data_in = d;
    qt_we   = we;
    qt_addr = a;
    qt_data = w;
    if (vld) begin
      exp_q.push_back({(tb_col == 3'd7), tb_col, e});
      tb_col = tb_col + 3'd1;
    end
    if (we) tb_tbl[a] = w;
  endtask

  task automatic send_model(input logic [7:0][11:0] d);
    logic [7:0][11:0] e;
    for (int r = 0; r < 8; r++) e[r] = ref_q(d[r], tb_tbl[r*8 + int'(tb_col)]);
    drive(1'b1, d, e, 1'b0, 6'd0, 16'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0, 1'b0, 6'd0, 16'd0);
  endtask

  task automatic rand_col(output logic [7:0][11:0] d);
    for (int r = 0; r < 8; r++) d[r] = 12'($urandom_range(0, 4095));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {blk_done, out_col, data_out}, 128'd0);
          if ({blk_done, out_col, data_out} == 100'd0) begin
            n_err++;
            $display("FAIL unexpected_out got=zero column exp=no output");
          end
        end else begin
          logic [99:0] e;
          e = exp_q.pop_front();
          check("out_column", {blk_done, out_col, data_out}, e);
        end
      end else if (blk_done) begin
        check("done_without_vld", blk_done, 1'b0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0]      idv [3];
    logic [11:0]      rv  [4];
    logic [11:0]      rx  [4];
    logic [7:0][11:0] d;
    logic [7:0][11:0] e;
    int               qv;
    int               rcp;

    idv = '{12'd100, 12'h800, 12'h7FF};
    rv  = '{12'h007, 12'h008, 12'hFF8, 12'hFF9};
    rx  = '{12'h000, 12'h001, 12'hFFF, 12'h000};

    rst = 1'b1; in_vld = 1'b0; data_in = '0; qt_we = 1'b0; qt_addr = '0; qt_data = '0;
    tb_col = 3'd0;
    for (int i = 0; i < 64; i++) tb_tbl[i] = 16'hFFFF;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {out_vld, blk_done, out_col, data_out}, 128'd0);
    @(negedge clk) rst = 1'b0;

    // identity table: output equals input
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 8; c++)
        drive(1'b1, splat(idv[k]), splat(idv[k]), 1'b0, 6'd0, 16'd0);

    // Q=16 on tbl[0]: ties round away from zero
    drive(1'b0, '0, '0, 1'b1, 6'd0, 16'd4096);
    for (int k = 0; k < 4; k++) begin
      d = splat(12'd5); d[0] = rv[k];
      e = splat(12'd5); e[0] = rx[k];
      drive(1'b1, d, e, 1'b0, 6'd0, 16'd0);
      for (int c = 1; c < 8; c++)
        drive(1'b1, splat(12'(c*3)), splat(12'(c*3)), 1'b0, 6'd0, 16'd0);
    end

    // 16-column stream with a 3-cycle gap after column 5
    for (int i = 0; i < 16; i++) begin
      rand_col(d);
      send_model(d);
      if (i == 5) idle(3);
    end

    // write collides with the read of tbl[2] at column 2
    send_model(splat(12'd24));
    send_model(splat(12'd24));
    drive(1'b1, splat(12'd24), splat(12'd24), 1'b1, 6'd2, 16'd4096);
    for (int c = 3; c < 8; c++) send_model(splat(12'd24));
    send_model(splat(12'd24));
    send_model(splat(12'd24));
    e = splat(12'd24); e[0] = 12'd2;
    drive(1'b1, splat(12'd24), e, 1'b0, 6'd0, 16'd0);
    for (int c = 3; c < 8; c++) send_model(splat(12'd24));

    // reset mid-block with column 3 in stage 1
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 8; r++)
        drive(1'b0, '0, '0, 1'b1, 6'(r*8 + c), 16'd4096);
    for (int c = 0; c < 4; c++) send_model(splat(12'd7));
    @(posedge clk);
    #1 in_vld = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    tb_col = 3'd0;
    for (int i = 0; i < 64; i++) tb_tbl[i] = 16'hFFFF;
    #1;
    check("rst_flush", {out_vld, blk_done, out_col, data_out}, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    drive(1'b1, splat(12'd7), splat(12'd7), 1'b0, 6'd0, 16'd0);
    for (int c = 1; c < 8; c++)
      drive(1'b1, splat(12'(c + 40)), splat(12'(c + 40)), 1'b0, 6'd0, 16'd0);

    // random tables and inputs
    for (int b = 0; b < 100; b++) begin
      for (int a = 0; a < 64; a++) begin
        qv  = $urandom_range(1, 255);
        rcp = (65536 + qv / 2) / qv;
        if (rcp > 65535) rcp = 65535;
        drive(1'b0, '0, '0, 1'b1, 6'(a), 16'(rcp));
      end
      for (int c = 0; c < 8; c++) begin
        rand_col(d);
        send_model(d);
      end
    end

    idle(4);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_empty", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
